// File: rtl/wtm_seq_mult10_pkg.sv
// wtm_seq_mult10_pkg: shared widths, FSM states and step helpers for the sequential 10x10 multiplier
package wtm_seq_mult10_pkg;
    localparam int CHUNK_W = 5;
    localparam int OP_W    = 10;
    localparam int PROD_W  = 20;
    localparam int PP_W    = 2 * CHUNK_W;
    localparam int STEP_SHIFT [4] = '{0, 5, 5, 10};
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef logic [1:0] step_t;
    // Returns {found, idx} for the lowest enabled step above cur.
    function automatic logic [2:0] next_step(input logic [3:0] mask, input step_t cur);
        logic [2:0] r;
        r = {1'b0, cur};
        for (int i = 3; i >= 0; i--)
            if (i > int'(cur) && mask[i]) r = {1'b1, step_t'(i)};
        return r;
    endfunction
    function automatic logic [PROD_W-1:0] place(input logic [PP_W-1:0] pp, input step_t s);
        return PROD_W'(pp) << STEP_SHIFT[s];
    endfunction
endpackage

// File: rtl/wtm_seq_mult10_wallace.sv
// wtm_seq_mult10_wallace: combinational 5x5 unsigned Wallace-tree multiplier
module wtm_seq_mult10_wallace
    import wtm_seq_mult10_pkg::*;
(
    input  logic [CHUNK_W-1:0] i_x,
    input  logic [CHUNK_W-1:0] i_y,
    output logic [PP_W-1:0]    o_p
);
    logic [PP_W-1:0] w_row [CHUNK_W];
    logic [PP_W-1:0] w_s1, w_c1, w_s2, w_c2, w_s3, w_c3;
    function automatic logic [2*PP_W-1:0] csa(input logic [PP_W-1:0] x, y, z);
        return {((x & y) | (x & z) | (y & z)) << 1, x ^ y ^ z};
    endfunction
    genvar i;
    generate
        for (i = 0; i < CHUNK_W; i++) begin : g_row
            assign w_row[i] = PP_W'({CHUNK_W{i_y[i]}} & i_x) << i;
        end
    endgenerate
    // Three 3:2 levels reduce five rows to sum/carry before the final adder.
    assign {w_c1, w_s1} = csa(w_row[0], w_row[1], w_row[2]);
    assign {w_c2, w_s2} = csa(w_s1, w_c1, w_row[3]);
    assign {w_c3, w_s3} = csa(w_s2, w_c2, w_row[4]);
    assign o_p = w_s3 + w_c3;
endmodule

// File: rtl/wtm_seq_mult10.sv
// wtm_seq_mult10: 10x10 unsigned multiplier sequencing four 5x5 partial products through one Wallace core
module wtm_seq_mult10
    import wtm_seq_mult10_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy
);
    state_t              r_state, w_next;
    logic [CHUNK_W-1:0]  r_al, r_ah, r_bl, r_bh, w_mx, w_my;
    logic [3:0]          r_mask, w_mask_new;
    step_t               r_step, w_nstep;
    logic                w_more;
    logic [PP_W-1:0]     w_pp;
    logic [PROD_W-1:0]   r_acc, r_product, w_sum;
    wire [CHUNK_W-1:0] w_ah = a[OP_W-1:CHUNK_W];
    wire [CHUNK_W-1:0] w_bh = b[OP_W-1:CHUNK_W];
    // Bit 0 of the step picks the a half, bit 1 the b half.
    assign w_mask_new = EARLY_EXIT ? {(w_ah != '0) && (w_bh != '0), w_bh != '0, w_ah != '0, 1'b1} : 4'hF;
    assign w_mx = r_step[0] ? r_ah : r_al;
    assign w_my = r_step[1] ? r_bh : r_bl;
    wtm_seq_mult10_wallace u_mul (
        .i_x(w_mx),
        .i_y(w_my),
        .o_p(w_pp)
    );
    assign w_sum = r_acc + place(w_pp, r_step);
    assign {w_more, w_nstep} = next_step(r_mask, r_step);
    always_comb begin
        w_next = r_state;
        w_next = r_state == IDLE ? (in_valid ? CALC : IDLE)
               : r_state == CALC ? (w_more ? CALC : DONE)
               : (out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_al      <= '0;
            r_ah      <= '0;
            r_bl      <= '0;
            r_bh      <= '0;
            r_mask    <= '0;
            r_step    <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && in_valid) begin
                r_al   <= a[CHUNK_W-1:0];
                r_ah   <= w_ah;
                r_bl   <= b[CHUNK_W-1:0];
                r_bh   <= w_bh;
                r_mask <= w_mask_new;
                r_step <= '0;
                r_acc  <= '0;
            end
            if (r_state == CALC) begin
                r_acc  <= w_sum;
                r_step <= w_nstep;
                if (!w_more) r_product <= w_sum;
            end
        end
    end
    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign busy      = r_state != IDLE;
    assign product   = r_product;
endmodule
